// File: rtl/simon_pkg.sv
// Shared Simon game types: segment code encoding and the playback state enum.
package simon_pkg;

    typedef logic [2:0] code_t;

    localparam code_t CODE_3    = 3'b011;
    localparam code_t CODE_2    = 3'b010;
    localparam code_t CODE_1    = 3'b001;
    localparam code_t CODE_0    = 3'b000;
    localparam int    EMPTY_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ON,
        ST_OFF,
        ST_DONE
    } play_state_t;

endpackage

// File: rtl/code_decode.sv
// Combinational segment code to one-hot LED pattern; empty or unknown codes give all-dark.
module code_decode
    import simon_pkg::*;
(
    input  code_t       i_code,
    output logic [3:0]  o_leds
);

    always_comb begin
        o_leds = 4'b0000;
        case (i_code)
            CODE_3:  o_leds = 4'b1000;
            CODE_2:  o_leds = 4'b0100;
            CODE_1:  o_leds = 4'b0010;
            CODE_0:  o_leds = 4'b0001;
            default: o_leds = 4'b0000;
        endcase
    end

endmodule

// File: rtl/sequence_playback.sv
// Plays segment[0..current_round] on the LEDs with timed on/off gaps, stopping early at an empty entry.
// Optional macro PLAYBACK_SPEEDUP_EN shortens on/off durations by last_index[4:3] in later rounds.
module sequence_playback
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000,
    parameter int CNT_W      = 25
)
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  code_t       i_segment [0:31],
    input  logic [4:0]  i_current_round,
    output logic [3:0]  o_leds,
    output logic        o_busy,
    output logic        o_done,
    output logic [4:0]  o_play_index
);

    play_state_t        r_state;
    play_state_t        w_next_state;
    logic [CNT_W-1:0]   r_timer;
    logic [4:0]         r_play_index;
    logic [4:0]         r_last_index;

    code_t              w_code;
    logic [3:0]         w_decoded;
    logic               w_empty;
    logic               w_timer_zero;
    logic               w_last_entry;
    logic [CNT_W-1:0]   w_on_load;
    logic [CNT_W-1:0]   w_off_load;

    assign w_code       = i_segment[r_play_index];
    assign w_empty      = w_code[EMPTY_BIT];
    assign w_timer_zero = (r_timer == '0);
    assign w_last_entry = (r_play_index == r_last_index);

`ifdef PLAYBACK_SPEEDUP_EN
    logic [CNT_W-1:0]   w_on_dur;
    logic [CNT_W-1:0]   w_off_dur;

    // A shift that reaches zero still yields a one-cycle phase.
    assign w_on_dur   = CNT_W'(ON_CYCLES) >> r_last_index[4:3];
    assign w_off_dur  = CNT_W'(OFF_CYCLES) >> r_last_index[4:3];
    assign w_on_load  = (w_on_dur == '0)  ? '0 : w_on_dur - 1'b1;
    assign w_off_load = (w_off_dur == '0) ? '0 : w_off_dur - 1'b1;
`else
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    assign w_on_load  = ON_LOAD;
    assign w_off_load = OFF_LOAD;
`endif

    code_decode u_code_decode (
        .i_code (w_code),
        .o_leds (w_decoded)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next_state = ST_FETCH;
            ST_FETCH: w_next_state = w_empty ? ST_DONE : ST_ON;
            ST_ON:    if (w_timer_zero) w_next_state = ST_OFF;
            ST_OFF:   if (w_timer_zero) w_next_state = w_last_entry ? ST_DONE : ST_FETCH;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Round is latched at start so mid-run changes cannot alter the length.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_timer      <= '0;
            r_play_index <= '0;
            r_last_index <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_last_index <= i_current_round;
                        r_play_index <= '0;
                    end
                end
                ST_FETCH: begin
                    if (!w_empty) r_timer <= w_on_load;
                end
                ST_ON: begin
                    if (w_timer_zero) r_timer <= w_off_load;
                    else              r_timer <= r_timer - 1'b1;
                end
                ST_OFF: begin
                    if (w_timer_zero) begin
                        if (!w_last_entry) r_play_index <= r_play_index + 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_leds       = 4'b0000;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_play_index = r_play_index;
        case (r_state)
            ST_IDLE:  ;
            ST_FETCH: o_busy = 1'b1;
            ST_ON: begin
                o_busy = 1'b1;
                o_leds = w_decoded;
            end
            ST_OFF:   o_busy = 1'b1;
            ST_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_sequence_playback.sv
// Directed self-checking bench for sequence_playback; cycle n is sampled 1 ns after the n-th edge following the start edge.
module tb_sequence_playback;
    import simon_pkg::*;

`ifdef PLAYBACK_SPEEDUP_EN
    localparam int TB_ON  = 8;
    localparam int TB_OFF = 8;
`else
    localparam int TB_ON  = 3;
    localparam int TB_OFF = 2;
`endif
    localparam int TB_P = 1 + TB_ON + TB_OFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    code_t       seg [0:31];
    logic [4:0]  round;
    logic [3:0]  leds;
    logic        busy;
    logic        done;
    logic [4:0]  idx;

    int n_vec = 0;
    int n_err = 0;

    sequence_playback #(
        .ON_CYCLES  (TB_ON),
        .OFF_CYCLES (TB_OFF),
        .CNT_W      (4)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_start         (start),
        .i_segment       (seg),
        .i_current_round (round),
        .o_leds          (leds),
        .o_busy          (busy),
        .o_done          (done),
        .o_play_index    (idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 ns");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [3:0] onehot(input code_t c);
        logic [3:0] r;
        case (c)
            3'b011:  r = 4'b1000;
            3'b010:  r = 4'b0100;
            3'b001:  r = 4'b0010;
            3'b000:  r = 4'b0001;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; round = 5'd0;
        for (int i = 0; i < 32; i++) seg[i] = 3'b000;
        tick(); tick();
        n_vec++; if (leds !== 4'b0000) begin n_err++; $display("FAIL reset_leds got %b want 0000", leds); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (idx !== 5'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", idx); end
        rst = 1'b0;
        tick(); tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int end_c, e, k;
        logic [3:0] el;
        seg[0] = 3'b011; seg[1] = 3'b000; round = 5'd1;
        end_c = 2 * TB_P + 1;
        pulse_start();
        for (int c = 1; c <= end_c + 1; c++) begin
            e = (c - 1) / TB_P; k = (c - 1) % TB_P;
            if (e > 1) e = 1;
            el = (c < end_c && k >= 1 && k <= TB_ON) ? onehot(seg[e]) : 4'b0000;
            n_vec++; if (leds !== el) begin n_err++; $display("FAIL basic_leds c=%0d got %b want %b", c, leds, el); end
            n_vec++; if (busy !== (c <= end_c)) begin n_err++; $display("FAIL basic_busy c=%0d got %b want %b", c, busy, c <= end_c); end
            n_vec++; if (done !== (c == end_c)) begin n_err++; $display("FAIL basic_done c=%0d got %b want %b", c, done, c == end_c); end
            if (c <= end_c) begin
                n_vec++; if (idx !== 5'(e)) begin n_err++; $display("FAIL basic_idx c=%0d got %0d want %0d", c, idx, e); end
            end
            tick();
        end
    endtask

    task automatic test_empty();
        seg[0] = 3'b100; round = 5'd3;
        pulse_start();
        n_vec++; if (busy !== 1'b1 || done !== 1'b0 || leds !== 4'b0000) begin
            n_err++; $display("FAIL empty_fetch got busy=%b done=%b leds=%b want 1 0 0000", busy, done, leds); end
        tick();
        n_vec++; if (done !== 1'b1 || leds !== 4'b0000 || idx !== 5'd0) begin
            n_err++; $display("FAIL empty_done got done=%b leds=%b idx=%0d want 1 0000 0", done, leds, idx); end
        tick();
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL empty_idle got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_early_stop();
        int end_c, e, k;
        logic [3:0] el;
        seg[0] = 3'b010; seg[1] = 3'b001; seg[2] = 3'b101; round = 5'd5;
        end_c = 2 * TB_P + 2;
        pulse_start();
        for (int c = 1; c <= end_c + 1; c++) begin
            e = (c - 1) / TB_P; k = (c - 1) % TB_P;
            if (e > 2) e = 2;
            el = (e < 2 && k >= 1 && k <= TB_ON) ? onehot(seg[e]) : 4'b0000;
            n_vec++; if (leds !== el) begin n_err++; $display("FAIL early_leds c=%0d got %b want %b", c, leds, el); end
            n_vec++; if (done !== (c == end_c)) begin n_err++; $display("FAIL early_done c=%0d got %b want %b", c, done, c == end_c); end
            n_vec++; if (busy !== (c <= end_c)) begin n_err++; $display("FAIL early_busy c=%0d got %b want %b", c, busy, c <= end_c); end
            if (c <= end_c) begin
                n_vec++; if (idx !== 5'(e)) begin n_err++; $display("FAIL early_idx c=%0d got %0d want %0d", c, idx, e); end
            end
            tick();
        end
    endtask

    task automatic test_ignored_start();
        int n_done, done_c;
        seg[0] = 3'b011; seg[1] = 3'b000; round = 5'd1;
        n_done = 0; done_c = -1;
        pulse_start();
        for (int c = 1; c <= 2 * TB_P + 8; c++) begin
            if (done === 1'b1) begin n_done++; done_c = c; end
            start = (c == 3 || c == TB_P + 3) ? 1'b1 : 1'b0;
            if (c == 5) round = 5'd4;
            tick();
        end
        start = 1'b0;
        n_vec++; if (n_done != 1) begin n_err++; $display("FAIL ignored_done_count got %0d want 1", n_done); end
        n_vec++; if (done_c != 2 * TB_P + 1) begin n_err++; $display("FAIL ignored_done_cycle got %0d want %0d", done_c, 2 * TB_P + 1); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignored_idle got busy=%b want 0", busy); end
        round = 5'd1;
    endtask

    task automatic test_reset_mid_on();
        bit seen;
        seg[0] = 3'b011; seg[1] = 3'b000; round = 5'd1;
        pulse_start();
        tick(); tick();
        n_vec++; if (leds !== 4'b1000) begin n_err++; $display("FAIL midreset_pre_leds got %b want 1000", leds); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (leds !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || idx !== 5'd0) begin
            n_err++; $display("FAIL midreset_async got leds=%b busy=%b done=%b idx=%0d want 0000 0 0 0", leds, busy, done, idx); end
        tick();
        rst = 1'b0;
        tick();
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midreset_after got busy=%b done=%b want 0 0", busy, done); end
        pulse_start();
        n_vec++; if (busy !== 1'b1 || idx !== 5'd0 || leds !== 4'b0000) begin
            n_err++; $display("FAIL midreset_refetch got busy=%b idx=%0d leds=%b want 1 0 0000", busy, idx, leds); end
        tick();
        n_vec++; if (leds !== 4'b1000) begin n_err++; $display("FAIL midreset_replay_leds got %b want 1000", leds); end
        seen = 1'b0;
        for (int c = 0; c < 4 * TB_P && !seen; c++) begin
            if (done === 1'b1) seen = 1'b1;
            tick();
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL midreset_drain got done=0 want done within %0d cycles", 4 * TB_P); end
        tick();
    endtask

    task automatic test_long_run(input int rnd, input int on, input int off);
        int p, end_c, e, k, n_done;
        logic [3:0] el;
        p = 1 + on + off;
        end_c = (rnd + 1) * p + 1;
        for (int i = 0; i < 32; i++) seg[i] = code_t'(i % 4);
        round = 5'(rnd);
        n_done = 0;
        pulse_start();
        for (int c = 1; c <= end_c + 1; c++) begin
            e = (c - 1) / p; k = (c - 1) % p;
            if (e > rnd) e = rnd;
            el = (c < end_c && k >= 1 && k <= on) ? onehot(seg[e]) : 4'b0000;
            if (done === 1'b1) n_done++;
            n_vec++; if (leds !== el) begin n_err++; $display("FAIL long_leds r=%0d c=%0d got %b want %b", rnd, c, leds, el); end
            if (c <= end_c) begin
                n_vec++; if (idx !== 5'(e)) begin n_err++; $display("FAIL long_idx r=%0d c=%0d got %0d want %0d", rnd, c, idx, e); end
            end
            n_vec++; if (done !== (c == end_c)) begin n_err++; $display("FAIL long_done r=%0d c=%0d got %b want %b", rnd, c, done, c == end_c); end
            tick();
        end
        n_vec++; if (n_done != 1) begin n_err++; $display("FAIL long_done_count r=%0d got %0d want 1", rnd, n_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_early_stop();
        test_ignored_start();
        test_reset_mid_on();
`ifdef PLAYBACK_SPEEDUP_EN
        test_long_run(16, TB_ON >> 2, TB_OFF >> 2);
        test_long_run(31, TB_ON >> 3, TB_OFF >> 3);
`else
        test_long_run(31, TB_ON, TB_OFF);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
